seq_mul_arbiter: RTL

- Shares one 8x8 sequential shift-add multiplier datapath among N_REQ requesters.
- Grants requests round-robin and latches the winner's operands.
- Sequences the multiplier through a load cycle and MUL_CYCLES run cycles, then captures the product.
- Returns the product to the granted requester with a one-cycle ack pulse. Sits between requesting client logic and the multiplier instance.

---
 rtl/seq_mul_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/seq_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seq_mul_arbiter
// Brief    : Round-robin arbiter sharing one sequential shift-add multiplier
//            among N_REQ requesters; returns each product with an ack pulse.
// Revision : 1.0
// ============================================================================
module seq_mul_arbiter #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_flat,
    input  logic [N_REQ*WIDTH-1:0]   b_flat,
    output logic [N_REQ-1:0]         ack,
    output logic [2*WIDTH-1:0]       result,
    output logic [2:0]               grant_id,
    output logic                     busy,
    output logic                     mul_enable,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    input  logic [2*WIDTH-1:0]       mul_c
);

    localparam int                CNT_W    = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [N_REQ-1:0]  ACK_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           rr_ptr_q, rr_ptr_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic [WIDTH-1:0]     mul_a_q, mul_a_d;
    logic [WIDTH-1:0]     mul_b_q, mul_b_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [N_REQ-1:0]     ack_q, ack_d;

    logic [N_REQ-1:0]     w_elig;
    logic [N_REQ-1:0]     w_shift;
    logic                 w_found;
    int                   w_idx;
    int                   w_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            result_q   <= '0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            result_q   <= result_d;
            ack_q      <= ack_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        result_d   = result_q;
        ack_d      = '0;
        w_found    = 1'b0;
        w_sel      = 0;
        w_idx      = 0;
        w_shift    = '0;
        // The requester being acked this cycle still holds req; mask it out.
        w_elig     = req & ~ack_q;

        for (int i = 0; i < N_REQ; i++) begin
            w_idx   = (int'(rr_ptr_q) + i) % N_REQ;
            w_shift = w_elig >> w_idx;
            if (!w_found && w_shift[0]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    mul_a_d    = WIDTH'(a_flat >> (w_sel * WIDTH));
                    mul_b_d    = WIDTH'(b_flat >> (w_sel * WIDTH));
                    grant_id_d = 3'(w_sel);
                    rr_ptr_d   = (w_sel == N_REQ - 1) ? 3'd0 : 3'(w_sel + 1);
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                result_d = mul_c;
                ack_d    = ACK_ONE << grant_id_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ack        = ack_q;
    assign result     = result_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q != S_IDLE);
    assign mul_enable = (state_q == S_RUN);
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;

endmodule
`default_nettype wire
